fetch_sequencer: RTL

- Instruction-fetch controller that owns the program counter and sequences fetches to instruction memory.
- Issues one request at a time on a req/gnt + rvalid interface.
- Holds each returned instruction until the decode stage accepts it.
- Applies branch/jump redirects and exception vectoring with correct squash of in-flight fetches.
- Sits between the PC/next-PC logic and the IF/ID boundary.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_sequencer_checker.sv | 19 +
 rtl/next_pc_sel.sv | 39 +++
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: sequencer state encoding and the default
// reset/exception vectors, also consumed by the exception/CP0 logic.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_checker.sv
// Interface checks for the fetch sequencer, observed from its ports only.
module fetch_sequencer_checker #(
  parameter int unsigned WORD_SIZE = 32
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 imem_req,
  input logic                 imem_gnt,
  input logic                 redirect_valid,
  input logic                 exc_valid,
  input logic [WORD_SIZE-1:0] imem_addr
);

  // A stalled request must keep presenting the same address unless redirected
  a_addr_stable: assert property (@(posedge clk) disable iff (!reset)
    (imem_req && !imem_gnt && !redirect_valid && !exc_valid) |=> (imem_req && $stable(imem_addr)))
    else $error("imem_addr changed while request stalled");

endmodule

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: exception beats branch/jump, which beats
// sequential advance; redirect targets are forced word-aligned.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int unsigned           WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0]  EXC_VECTOR = WORD_SIZE'(DEF_EXC_VECTOR)
) (
  input  logic [WORD_SIZE-1:0] pc_i,
  input  logic                 exc_valid_i,
  input  logic                 redirect_valid_i,
  input  logic [WORD_SIZE-1:0] redirect_addr_i,
  input  logic                 advance_i,
  output logic [WORD_SIZE-1:0] next_pc_o,
  output logic                 redirect_o
);

  localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(INSTR_BYTES);

  logic [WORD_SIZE-1:0] target_s;

  // Select redirect target and next PC; pc+4 wraps naturally at the word width
  always_comb begin
    redirect_o = exc_valid_i | redirect_valid_i;
    if (exc_valid_i) begin
      target_s = EXC_VECTOR;
    end else begin
      target_s = redirect_addr_i;
    end
    if (redirect_o) begin
      next_pc_o = {target_s[WORD_SIZE-1:2], 2'b00};
    end else if (advance_i) begin
      next_pc_o = pc_i + STEP;
    end else begin
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// holds the returned instruction for decode and squashes fetches on redirect.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned          WORD_SIZE    = 32,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = WORD_SIZE'(DEF_RESET_VECTOR),
  parameter logic [WORD_SIZE-1:0] EXC_VECTOR   = WORD_SIZE'(DEF_EXC_VECTOR)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_addr,
  input  logic                 exc_valid,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] if_instr
);

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] pending_pc_q, pending_pc_d;
  logic [WORD_SIZE-1:0] if_pc_q, if_pc_d;
  logic [WORD_SIZE-1:0] if_instr_q, if_instr_d;
  logic                 advance_s;
  logic                 deliver_s;
  logic                 redirect_s;

  assign advance_s = (state_q == WAIT) && imem_rvalid;
  assign deliver_s = advance_s && !redirect_s;

  next_pc_sel #(
    .WORD_SIZE  (WORD_SIZE),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc_sel (
    .pc_i             (pc_q),
    .exc_valid_i      (exc_valid),
    .redirect_valid_i (redirect_valid),
    .redirect_addr_i  (redirect_addr),
    .advance_i        (advance_s),
    .next_pc_o        (pc_d),
    .redirect_o       (redirect_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rvalid is ignored in REQ and HOLD
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        if (imem_gnt) begin
          state_d = redirect_s ? FLUSH : WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = redirect_s ? REQ : HOLD;
        end else if (redirect_s) begin
          state_d = FLUSH;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (redirect_s || if_ready) begin
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      FLUSH: begin
        // The stale response closes the flush even if another redirect lands with it
        if (imem_rvalid) begin
          state_d = REQ;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // Outputs; the request is gated by reset so it drops without a clock edge
  always_comb begin
    imem_req  = reset && (state_q == REQ);
    imem_addr = pc_q;
    if_valid  = (state_q == HOLD);
    if_pc     = if_pc_q;
    if_instr  = if_instr_q;
  end

  // Datapath next values: capture the accepted address and the delivered word
  always_comb begin
    pending_pc_d = pending_pc_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if ((state_q == REQ) && imem_gnt) begin
      pending_pc_d = pc_q;
    end else begin
      pending_pc_d = pending_pc_q;
    end
    if (deliver_s) begin
      if_pc_d    = pending_pc_q;
      if_instr_d = imem_rdata;
    end else begin
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      pending_pc_q <= '0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

  fetch_sequencer_checker #(
    .WORD_SIZE (WORD_SIZE)
  ) u_checker (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_gnt       (imem_gnt),
    .redirect_valid (redirect_valid),
    .exc_valid      (exc_valid),
    .imem_addr      (imem_addr)
  );

endmodule
